// File: rtl/pipe_fwd_scoreboard.sv
// ID-stage hazard scoreboard: shadows dest/latency of the NFWD post-ID stages and
// derives per-operand forwarding selects, the freeze signal, issue and a stall counter.
module pipe_fwd_scoreboard #(
    parameter int AW   = 5,
    parameter int NFWD = 2,
    parameter int FW   = $clog2(NFWD+1),
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          id_valid,
    input  logic          id_wreg,
    input  logic [AW-1:0] id_rn,
    input  logic [FW-1:0] id_lat,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          cancel,
    input  logic          kill_e,
    output logic [FW-1:0] fwda,
    output logic [FW-1:0] fwdb,
    output logic          nostall,
    output logic          issue,
    output logic [CW-1:0] stall_cnt
);

    logic [NFWD:1]         r_v;
    logic [NFWD:1][AW-1:0] r_rn;
    logic [NFWD:1][FW-1:0] r_rdy;
    logic [CW-1:0]         r_cnt;

    logic                  w_req;
    logic                  w_hazard;
    logic [FW-1:0]         w_rdy_in;

    // One lookup per source operand; the youngest matching stage decides.
    for (genvar op = 0; op < 2; op++) begin : g_op
        logic [AW-1:0] w_src;
        logic          w_use;
        logic [FW-1:0] w_sel;
        logic          w_haz;
        logic          w_hit;

        assign w_src = (op == 0) ? id_rs : id_rt;
        assign w_use = (op == 0) ? id_use_rs : id_use_rt;

        always_comb begin
            w_sel = '0;
            w_haz = 1'b0;
            w_hit = 1'b0;
            for (int k = 1; k <= NFWD; k++) begin
                if (!w_hit && w_use && r_v[k] && !(k == 1 && kill_e) &&
                    r_rn[k] == w_src && w_src != '0) begin
                    w_hit = 1'b1;
                    if (FW'(k) >= r_rdy[k])
                        w_sel = FW'(k);
                    else
                        w_haz = 1'b1;
                end
            end
        end
    end

    assign w_req    = id_valid & ~cancel;
    assign w_hazard = g_op[0].w_haz | g_op[1].w_haz;
    assign nostall  = ~(w_req & w_hazard);
    assign issue    = w_req & nostall;
    assign fwda     = g_op[0].w_sel;
    assign fwdb     = g_op[1].w_sel;
    assign stall_cnt = r_cnt;

    // A latency of 0 is treated as forwardable from stage 1.
    assign w_rdy_in = (id_lat == '0) ? FW'(1) : id_lat;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_v   <= '0;
            r_rn  <= '0;
            r_rdy <= '0;
        end else begin
            r_v[1]   <= issue & id_wreg & (id_rn != '0);
            r_rn[1]  <= id_rn;
            r_rdy[1] <= w_rdy_in;
            // kill_e squashes what is leaving stage 1, so stage 2 gets a bubble.
            for (int k = 2; k <= NFWD; k++) begin
                r_v[k]   <= r_v[k-1] & ~(kill_e & (k == 2));
                r_rn[k]  <= r_rn[k-1];
                r_rdy[k] <= r_rdy[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_cnt <= '0;
        else if (w_req && !nostall && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_fwd_scoreboard.sv
// Directed bench for pipe_fwd_scoreboard (NFWD=3, CW=3 so saturation is reachable),
// checked every cycle against an age-based model of in-flight producers.
module tb_pipe_fwd_scoreboard;
    localparam int AW = 5, NFWD = 3, FW = 2, CW = 3;

    logic clk = 1'b0, clr = 1'b1;
    logic id_valid = 0, id_wreg = 0, id_use_rs = 0, id_use_rt = 0, cancel = 0, kill_e = 0;
    logic [AW-1:0] id_rn = 0, id_rs = 0, id_rt = 0;
    logic [FW-1:0] id_lat = 0;
    logic [FW-1:0] fwda, fwdb;
    logic nostall, issue;
    logic [CW-1:0] stall_cnt;

    pipe_fwd_scoreboard #(.AW(AW), .NFWD(NFWD), .FW(FW), .CW(CW)) dut (
        .clk(clk), .clr(clr), .id_valid(id_valid), .id_wreg(id_wreg), .id_rn(id_rn),
        .id_lat(id_lat), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .cancel(cancel), .kill_e(kill_e), .fwda(fwda),
        .fwdb(fwdb), .nostall(nostall), .issue(issue), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each issued writer is remembered with the cycle it reaches stage 1;
    // its stage at any cycle is simply its age.
    typedef struct {int rn; int rdy; int enter; bit killed;} rec_t;
    rec_t q[$];
    int exp_cnt = 0;

    function automatic void lookup(input int s, input bit use_s, output int sel, output bit haz);
        int best, brdy, st;
        best = 0; brdy = 0; sel = 0; haz = 0;
        if (!use_s || s == 0) return;
        foreach (q[i]) begin
            st = cyc - q[i].enter + 1;
            if (st < 1 || st > NFWD || q[i].killed) continue;
            if (kill_e && st == 1) continue;
            if (q[i].rn != s) continue;
            if (best == 0 || st < best) begin best = st; brdy = q[i].rdy; end
        end
        if (best == 0) return;
        if (best >= brdy) sel = best; else haz = 1;
    endfunction

    always @(negedge clk) begin
        int sa, sb;
        bit ha, hb, req, ens, eis;
        rec_t r;
        if (clr) begin
            q.delete();
            exp_cnt = 0;
        end
        lookup(int'(id_rs), id_use_rs, sa, ha);
        lookup(int'(id_rt), id_use_rt, sb, hb);
        req = id_valid && !cancel;
        ens = !(req && (ha || hb));
        eis = req && ens;
        chk("fwda", int'(fwda), sa);
        chk("fwdb", int'(fwdb), sb);
        chk("nostall", int'(nostall), int'(ens));
        chk("issue", int'(issue), int'(eis));
        chk("stall_cnt", int'(stall_cnt), exp_cnt);
        if (!clr) begin
            if (kill_e)
                foreach (q[i]) if (q[i].enter == cyc) q[i].killed = 1;
            if (req && !ens && exp_cnt < (1 << CW) - 1) exp_cnt++;
            if (eis && id_wreg && id_rn != 0) begin
                r.rn = int'(id_rn);
                r.rdy = (id_lat == 0) ? 1 : int'(id_lat);
                r.enter = cyc + 1;
                r.killed = 0;
                q.push_back(r);
            end
            while (q.size() > 0 && cyc - q[0].enter + 1 > NFWD) void'(q.pop_front());
        end
    end

    // Drive one ID cycle; returns just after the negedge so outputs are settled.
    task automatic step(input bit v, input bit w, input int rn, input int lat,
                        input int rs, input bit urs, input int rt, input bit urt,
                        input bit cn, input bit kl);
        @(posedge clk); #1;
        id_valid = v; id_wreg = w; id_rn = AW'(rn); id_lat = FW'(lat);
        id_rs = AW'(rs); id_use_rs = urs; id_rt = AW'(rt); id_use_rt = urt;
        cancel = cn; kill_e = kl;
        @(negedge clk); #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk); #1;
        chk("rst_nostall", int'(nostall), 1);
        chk("rst_fwda", int'(fwda), 0);
        chk("rst_cnt", int'(stall_cnt), 0);

        // ALU chain
        step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_issue", int'(issue), 1);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        chk("alu_fwd1", int'(fwda), 1);
        chk("alu_nostall", int'(nostall), 1);
        nops(3);
        step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        nops(1);
        step(1, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        chk("alu_fwd2", int'(fwda), 2);
        nops(3);

        // load-use
        step(1, 1, 4, 2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        chk("lu_nostall", int'(nostall), 0);
        chk("lu_issue", int'(issue), 0);
        step(1, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        chk("lu_cnt", int'(stall_cnt), 1);
        chk("lu_fwd", int'(fwda), 2);
        chk("lu_issue2", int'(issue), 1);
        nops(3);

        // priority, unused source, r0
        step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 5, 1, 0, 0);
        chk("pri_fwdb", int'(fwdb), 1);
        chk("unused_fwda", int'(fwda), 0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_fwda", int'(fwda), 0);
        chk("r0_nostall", int'(nostall), 1);
        nops(3);

        // kill of a load, with a writer issuing in the same cycle
        step(1, 1, 4, 2, 0, 0, 0, 0, 0, 0);
        step(1, 1, 10, 1, 4, 1, 0, 0, 0, 1);
        chk("kill_nostall", int'(nostall), 1);
        chk("kill_fwda", int'(fwda), 0);
        step(1, 0, 0, 0, 4, 1, 10, 1, 0, 0);
        chk("kill_after", int'(fwda), 0);
        chk("kill_newfwd", int'(fwdb), 1);
        nops(3);

        // kill exposes an older writer of the same register
        step(1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 2, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 7, 1, 0, 0, 0, 1);
        chk("kill_older", int'(fwda), 2);
        nops(3);

        // latency 3: two stalls then forward from stage 3
        step(1, 1, 6, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        chk("l3_fwd", int'(fwda), 3);
        chk("l3_cnt", int'(stall_cnt), 3);
        nops(3);

        // cancel during hazard
        step(1, 1, 6, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 6, 1, 0, 0, 1, 0);
        chk("cn_nostall", int'(nostall), 1);
        chk("cn_issue", int'(issue), 0);
        nops(1);
        chk("cn_cnt", int'(stall_cnt), 3);
        nops(2);

        // latency 0 behaves as 1
        step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 8, 1, 8, 1, 0, 0);
        chk("lat0_fwda", int'(fwda), 1);
        nops(3);

        // drive the counter into saturation
        for (int j = 0; j < 3; j++) begin
            step(1, 1, 9, 3, 0, 0, 0, 0, 0, 0);
            repeat (3) step(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        end
        chk("sat_cnt", int'(stall_cnt), 7);

        // mid-stream clear empties the scoreboard
        step(1, 1, 11, 3, 0, 0, 0, 0, 0, 0);
        #1 clr = 1'b1;
        step(1, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        chk("clr_nostall", int'(nostall), 1);
        chk("clr_cnt", int'(stall_cnt), 0);
        #1 clr = 1'b0;
        nops(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
